si5324_i2c_write_engine: RTL and testbench

SI5324_I2C_WRITE_ENGINE -- requirements
Module: si5324_i2c_write_engine

---
 rtl/si5324_i2c_write_engine_if.sv | 29 ++
 rtl/si5324_i2c_write_engine.sv | 185 ++++++++++++++++++
 tb/tb_si5324_i2c_write_engine.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/si5324_i2c_write_engine_if.sv
// Request/status bundle between a requester and the SI5324 I2C write engine.
// master: the requester side; slave: the engine that serves requests.
// The open-drain sda net stays a plain inout so the wired-AND resolves at the top level.
interface si5324_i2c_write_engine_if;
   logic        start;
   logic [23:0] data_in;
   logic        scl;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      output start,
      output data_in,
      input  scl,
      input  busy,
      input  done,
      input  error
   );

   modport slave (
      input  start,
      input  data_in,
      output scl,
      output busy,
      output done,
      output error
   );
endinterface

// File: rtl/si5324_i2c_write_engine.sv
// Single-shot I2C write engine: START, {addr,W}, register, data, STOP.
// Every bus phase is built from quarter-periods of SCL; outputs decode directly
// from state so an asynchronous reset releases the bus in the same cycle.
module si5324_i2c_write_engine #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned I2C_FREQ = 100_000
) (
   input  logic                            clk,
   input  logic                            reset,
   si5324_i2c_write_engine_if.slave        bus,
   inout  wire                             sda
);

   localparam int unsigned QDIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
   localparam int unsigned QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
   localparam int unsigned DIV_W    = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(QDIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBit,
      StAck,
      StStop,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       qtr_q, qtr_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       byte_q, byte_d;
   logic [23:0]      shift_q, shift_d;
   logic             error_q, error_d;
   logic             tick;
   logic             scl_drv;
   logic             sda_low;
   logic             unused_data_msb;

   // Bit 23 of the request word carries no meaning on the bus
   assign unused_data_msb = bus.data_in[23];

   assign tick = (div_q == DIV_MAX);

   // State and datapath registers; reset returns to idle without emitting a STOP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         div_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         error_q <= error_d;
      end
   end

   // Next state: quarter sequencing, bit/byte counting and ACK sampling
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      error_d = error_q;

      if (state_q inside {StIdle, StDone}) begin
         div_d = '0;
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StStart;
               // First byte on the wire is {addr[6:0], W=0}
               shift_d = {bus.data_in[22:16], 1'b0, bus.data_in[15:0]};
               error_d = 1'b0;
               qtr_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
            end
         end
         StStart: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd1) begin
                  state_d = StBit;
                  qtr_d   = '0;
               end
            end
         end
         StBit: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  shift_d = {shift_q[22:0], 1'b0};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = StAck;
                  end
               end
            end
         end
         StAck: begin
            // Sample once, on the first clock of the second high quarter
            if ((qtr_q == 2'd2) && (div_q == '0) && sda) begin
               error_d = 1'b1;
            end
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  if (error_q || (byte_q == 2'd2)) begin
                     state_d = StStop;
                  end else begin
                     state_d = StBit;
                     byte_d  = byte_q + 2'd1;
                  end
               end
            end
         end
         StStop: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd2) begin
                  state_d = StDone;
                  qtr_d   = '0;
               end
            end
         end
         StDone: begin
            if (!bus.start) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Bus levels per phase and quarter; sda is only ever pulled low or released
   always_comb begin
      scl_drv = 1'b1;
      sda_low = 1'b0;
      unique case (state_q)
         StStart: begin
            scl_drv = (qtr_q == 2'd0);
            sda_low = 1'b1;
         end
         StBit: begin
            scl_drv = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            sda_low = ~shift_q[23];
         end
         StAck: begin
            scl_drv = (qtr_q == 2'd1) || (qtr_q == 2'd2);
         end
         StStop: begin
            scl_drv = (qtr_q != 2'd0);
            sda_low = (qtr_q != 2'd2);
         end
         default: begin
            scl_drv = 1'b1;
            sda_low = 1'b0;
         end
      endcase
   end

   assign bus.scl   = scl_drv;
   assign bus.busy  = state_q inside {StStart, StBit, StAck, StStop};
   assign bus.done  = (state_q == StDone);
   assign bus.error = error_q;
   assign sda       = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_si5324_i2c_write_engine.sv
// Bench for the SI5324 I2C write engine: random requests, an ACK/NACK slave model,
// a per-cycle expected-waveform scoreboard and per-transaction result records.
module tb_si5324_i2c_write_engine;

   localparam int unsigned CLK_FREQ = 4_000_000;
   localparam int unsigned I2C_FREQ = 100_000;
   localparam int unsigned QDIV     = CLK_FREQ / (4 * I2C_FREQ);

   typedef struct packed {
      logic [23:0] bytes;
      logic [1:0]  nack_at;
      logic [1:0]  nb;
      logic        err;
      logic [15:0] cycles;
   } rec_t;

   logic clk;
   logic reset;
   wire  sda;
   logic slave_pull;

   si5324_i2c_write_engine_if bus_if ();

   si5324_i2c_write_engine #(
      .CLK_FREQ (CLK_FREQ),
      .I2C_FREQ (I2C_FREQ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave),
      .sda   (sda)
   );

   pullup (sda);
   assign sda = slave_pull ? 1'b0 : 1'bz;

   int         n_vec;
   int         n_fail;
   logic [1:0] wave_q[$];
   rec_t       rec_q[$];
   logic       rx_bits[$];

   // Monitor state
   logic       prev_scl, prev_busy, prev_done, seen_rise, rise_bit, exp_sda, nack_now;
   logic [1:0] w;
   int         pulses, cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input string why);
      n_vec++;
      n_fail++;
      $display("FAIL %s: %s", name, why);
   endtask

   task automatic add_quarter(input logic s, input logic low);
      repeat (QDIV) wave_q.push_back({s, low});
   endtask

   // Reference: waveform and outcome derived from the protocol description
   task automatic push_expect(input logic [23:0] d, input int nack_at);
      logic [7:0] b[3];
      int         nb;
      int         quarters;
      rec_t       r;
      b[0] = {d[22:16], 1'b0};
      b[1] = d[15:8];
      b[2] = d[7:0];
      nb = (nack_at == 0) ? 3 : nack_at;
      add_quarter(1'b1, 1'b1);
      add_quarter(1'b0, 1'b1);
      for (int k = 0; k < nb; k++) begin
         for (int i = 7; i >= 0; i--) begin
            add_quarter(1'b0, !b[k][i]);
            add_quarter(1'b1, !b[k][i]);
            add_quarter(1'b1, !b[k][i]);
            add_quarter(1'b0, !b[k][i]);
         end
         add_quarter(1'b0, 1'b0);
         add_quarter(1'b1, 1'b0);
         add_quarter(1'b1, 1'b0);
         add_quarter(1'b0, 1'b0);
      end
      add_quarter(1'b0, 1'b1);
      add_quarter(1'b1, 1'b1);
      add_quarter(1'b1, 1'b0);
      quarters  = 2 + 36 * nb + 3;
      r.bytes   = {b[0], b[1], b[2]};
      r.nack_at = 2'(nack_at);
      r.nb      = 2'(nb);
      r.err     = (nack_at != 0);
      r.cycles  = 16'(quarters * QDIV);
      rec_q.push_back(r);
   endtask

   task automatic check_txn();
      rec_t       r;
      logic [7:0] got;
      int         nb;
      if (rec_q.size() == 0) begin
         flag("txn_unexpected", "done rose with no outstanding request");
         return;
      end
      r  = rec_q.pop_front();
      nb = int'(r.nb);
      chk("txn_cycles", 32'(cyc), 32'(r.cycles));
      chk("txn_pulses", 32'(pulses), 32'(9 * nb));
      chk("txn_error", 32'(bus_if.error), 32'(r.err));
      chk("txn_busy_low", 32'(bus_if.busy), 32'd0);
      chk("txn_wave_left", 32'(wave_q.size()), 32'd0);
      wave_q.delete();
      if (rx_bits.size() == 9 * nb) begin
         for (int k = 0; k < nb; k++) begin
            got = '0;
            for (int i = 0; i < 8; i++) got = {got[6:0], rx_bits[9 * k + i]};
            chk($sformatf("txn_byte%0d", k), 32'(got), 32'(r.bytes[23 - 8 * k -: 8]));
            chk($sformatf("txn_ack%0d", k), 32'(rx_bits[9 * k + 8]),
                32'((k + 1) == int'(r.nack_at)));
         end
      end
   endtask

   // Monitor + slave: compare every cycle, decode pulses, ACK unless told to NACK
   always @(negedge clk) begin
      if (reset) begin
         slave_pull = 1'b0;
         prev_scl   = 1'b1;
         prev_busy  = 1'b0;
         prev_done  = 1'b0;
         seen_rise  = 1'b0;
      end else begin
         if (bus_if.busy && !prev_busy) begin
            pulses    = 0;
            cyc       = 0;
            seen_rise = 1'b0;
            rx_bits.delete();
         end
         if (bus_if.busy) begin
            cyc++;
            if (wave_q.size() == 0) begin
               flag("wave_overrun", "busy longer than the expected transaction");
            end else begin
               w       = wave_q.pop_front();
               exp_sda = !(w[0] || slave_pull);
               chk("wave_scl", 32'(bus_if.scl), 32'(w[1]));
               chk("wave_sda", 32'(sda), 32'(exp_sda));
            end
         end else begin
            chk("idle_scl", 32'(bus_if.scl), 32'd1);
            chk("idle_sda", 32'(sda), 32'd1);
         end
         if (bus_if.busy && bus_if.scl && !prev_scl) begin
            seen_rise = 1'b1;
            rise_bit  = sda;
         end
         if (bus_if.busy && !bus_if.scl && prev_scl) begin
            if (seen_rise) begin
               pulses++;
               rx_bits.push_back(rise_bit);
               seen_rise = 1'b0;
            end
            nack_now   = (rec_q.size() > 0) && (int'(rec_q[0].nack_at) == pulses / 9 + 1);
            slave_pull = (pulses % 9 == 8) && !nack_now;
         end
         if (bus_if.done && !prev_done) check_txn();
         prev_scl  = bus_if.scl;
         prev_busy = bus_if.busy;
         prev_done = bus_if.done;
      end
   end

   task automatic issue(input logic [23:0] d, input int nack_at, input bit hold);
      push_expect(d, nack_at);
      @(posedge clk);
      #1;
      bus_if.data_in = d;
      bus_if.start   = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus_if.start = 1'b0;
      chk("accept_busy", 32'(bus_if.busy), 32'd1);
      chk("accept_error_clear", 32'(bus_if.error), 32'd0);
   endtask

   task automatic wait_done(input bit scramble, input logic exp_err, input int hold_cycles);
      int n;
      n = 0;
      while (!bus_if.done && n < 2000) begin
         @(posedge clk);
         #1;
         if (scramble) bus_if.data_in = 24'($urandom);
         n++;
      end
      if (!bus_if.done) begin
         flag("done_timeout", "done never rose within 2000 cycles");
         bus_if.start = 1'b0;
         return;
      end
      for (int i = 0; i < hold_cycles; i++) begin
         @(posedge clk);
         #1;
         chk("hold_done", 32'(bus_if.done), 32'd1);
      end
      bus_if.start = 1'b0;
      @(posedge clk);
      #1;
      chk("done_fall", 32'(bus_if.done), 32'd0);
      @(posedge clk);
      #1;
      chk("idle_busy", 32'(bus_if.busy), 32'd0);
      chk("idle_error_hold", 32'(bus_if.error), 32'(exp_err));
   endtask

   task automatic run(input logic [23:0] d, input int nack_at, input bit scramble);
      issue(d, nack_at, 1'b0);
      wait_done(scramble, nack_at != 0, 0);
   endtask

   initial begin
      logic [23:0] d;
      int          na;
      n_vec          = 0;
      n_fail         = 0;
      slave_pull     = 1'b0;
      reset          = 1'b1;
      bus_if.start   = 1'b0;
      bus_if.data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_scl", 32'(bus_if.scl), 32'd1);
      chk("rst_sda", 32'(sda), 32'd1);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_done", 32'(bus_if.done), 32'd0);
      chk("rst_error", 32'(bus_if.error), 32'd0);

      // Baseline write, address NACK, data NACK then a clean write
      run(24'h680052, 0, 1'b0);
      run(24'h680052, 1, 1'b0);
      run(24'hE80052, 3, 1'b0);
      run(24'h680052, 0, 1'b0);

      // Reset in idle clears a latched error
      run(24'h123456, 2, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("idle_rst_error", 32'(bus_if.error), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Start held high long after done must not retrigger
      issue(24'h5A3CC3, 0, 1'b1);
      wait_done(1'b0, 1'b0, 2000);

      // Reset in the middle of bit 4 of the register byte (driving low)
      issue(24'h680052, 0, 1'b0);
      repeat (560) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_scl", 32'(bus_if.scl), 32'd1);
      chk("midrst_sda", 32'(sda), 32'd1);
      chk("midrst_busy", 32'(bus_if.busy), 32'd0);
      chk("midrst_done", 32'(bus_if.done), 32'd0);
      rec_q.delete();
      wave_q.delete();
      bus_if.data_in = 24'h688001;
      bus_if.start   = 1'b1;
      push_expect(24'h688001, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_accept", 32'(bus_if.busy), 32'd1);
      bus_if.start = 1'b0;
      wait_done(1'b0, 1'b0, 0);

      // data_in churns every cycle after acceptance
      run(24'($urandom), 0, 1'b1);

      // Random requests with random ACK/NACK placement
      for (int t = 0; t < 6; t++) begin
         d  = 24'($urandom);
         na = int'($urandom_range(0, 3));
         run(d, na, t[0]);
      end

      repeat (5) @(posedge clk);
      if (rec_q.size() != 0) flag("leftover_requests", "expected transactions never completed");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
